// File: rtl/hamming_code_decoder.sv
// Hamming(7,4) SEC decoder, 2-stage valid/ready pipe; optional error counter via HAMMING_DEC_ERR_CNT_EN.
// Latency: 2 edges from input transfer to out_valid; 1 word/clock sustained.
// Backpressure: in_ready combinational from out_ready; holds 2 words, outputs stable while stalled.
module hamming_code_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:1]       code_in,
    input  logic             parity_type,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:1]       data_out,
    output logic             err_detected,
    output logic [3:1]       err_pos,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] err_count
);

    logic       s1_valid_q;
    logic [7:1] s1_code_q;
    logic       s1_pt_q;

    logic       out_valid_q;
    logic [4:1] data_q;
    logic       err_q;
    logic [3:1] pos_q;

    logic [3:1] syn_d;
    logic [4:1] data_d;
    logic       s2_load;
    logic       s1_adv;

    assign s2_load  = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_load;
    assign in_ready = s1_adv && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_code_q  <= '0;
            s1_pt_q    <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_code_q <= code_in;
                s1_pt_q   <= parity_type;
            end
        end
    end

    always_comb begin
        syn_d[1] = ^{s1_code_q[1], s1_code_q[3], s1_code_q[5], s1_code_q[7], s1_pt_q};
        syn_d[2] = ^{s1_code_q[2], s1_code_q[3], s1_code_q[6], s1_code_q[7], s1_pt_q};
        syn_d[3] = ^{s1_code_q[4], s1_code_q[5], s1_code_q[6], s1_code_q[7], s1_pt_q};
        // Only data positions need the flip; a parity-position error leaves data untouched.
        data_d[1] = s1_code_q[3] ^ (syn_d == 3'd3);
        data_d[2] = s1_code_q[5] ^ (syn_d == 3'd5);
        data_d[3] = s1_code_q[6] ^ (syn_d == 3'd6);
        data_d[4] = s1_code_q[7] ^ (syn_d == 3'd7);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            err_q       <= 1'b0;
            pos_q       <= '0;
        end else if (s2_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                data_q <= data_d;
                err_q  <= (syn_d != 3'd0);
                pos_q  <= syn_d;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign data_out     = data_q;
    assign err_detected = err_q;
    assign err_pos      = pos_q;

`ifdef HAMMING_DEC_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_valid_q && out_ready && err_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_count = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign err_count      = '0;
`endif

endmodule

// File: tb/tb_hamming_code_decoder.sv
// Bench for hamming_code_decoder: scoreboard of brute-force-decoded words plus directed scenarios.
module tb_hamming_code_decoder;
    localparam int CNT_W = 2;
`ifdef HAMMING_DEC_ERR_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:1]       code_in = '0;
    logic             parity_type = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [4:1]       data_out;
    logic             err_detected;
    logic [3:1]       err_pos;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] err_count;

    int               n_tests = 0;
    int               n_fail = 0;
    int               n_out = 0;
    int               n_in = 0;
    logic [7:0]       sbq[$];
    logic [CNT_W-1:0] exp_cnt = '0;
    bit               mon_en = 1'b0;
    logic [7:0]       got;
    logic [7:0]       expv;
    bit               xfer;

    always #5 clk = ~clk;

    hamming_code_decoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .code_in(code_in), .parity_type(parity_type), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .err_detected(err_detected),
        .err_pos(err_pos), .cnt_clr(cnt_clr), .err_count(err_count)
    );

    // Nearest-codeword search: encode every data value, try every single flip.
    function automatic logic [7:0] model(input logic [7:1] c, input logic pt);
        logic [7:1] cw;
        logic [3:0] dv;
        for (int d = 0; d < 16; d++) begin
            for (int p = 0; p < 8; p++) begin
                dv    = 4'(d);
                cw[3] = dv[0];
                cw[5] = dv[1];
                cw[6] = dv[2];
                cw[7] = dv[3];
                cw[1] = dv[0] ^ dv[1] ^ dv[3] ^ pt;
                cw[2] = dv[0] ^ dv[2] ^ dv[3] ^ pt;
                cw[4] = dv[1] ^ dv[2] ^ dv[3] ^ pt;
                if (p != 0) cw[p] = ~cw[p];
                if (cw == c) return {dv, (p != 0), 3'(p)};
            end
        end
        return 8'h00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            n_tests++;
            if (err_count !== exp_cnt) begin
                n_fail++;
                $display("FAIL err_count_track: got %0d expected %0d at %0t", err_count, exp_cnt, $time);
            end
            if (rst) begin
                sbq.delete();
                exp_cnt = '0;
            end else begin
                xfer = out_valid && out_ready;
                if (xfer) begin
                    n_out++;
                    got = {data_out, err_detected, err_pos};
                    n_tests++;
                    if (sbq.size() == 0) begin
                        n_fail++;
                        $display("FAIL scoreboard_unexpected: got %h expected no output at %0t", got, $time);
                    end else begin
                        expv = sbq.pop_front();
                        if (got !== expv) begin
                            n_fail++;
                            $display("FAIL scoreboard_word: got %h expected %h at %0t", got, expv, $time);
                        end
                    end
                end
`ifdef HAMMING_DEC_ERR_CNT_EN
                if (cnt_clr) exp_cnt = '0;
                else if (xfer && err_detected && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
`endif
                if (in_valid && in_ready) begin
                    sbq.push_back(model(code_in, parity_type));
                    n_in++;
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++;
        if (data_out !== 4'b0000) begin n_fail++; $display("FAIL reset_data_out: got %b expected 0000", data_out); end
        n_tests++;
        if (err_detected !== 1'b0 || err_pos !== 3'b000) begin
            n_fail++; $display("FAIL reset_err: got %b/%b expected 0/000", err_detected, err_pos);
        end
        n_tests++;
        if (err_count !== '0) begin n_fail++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
        rst = 1'b0;
        mon_en = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_vectors();
        logic [7:1] vc[5] = '{7'b0000111, 7'b1000000, 7'b0010111, 7'b0000110, 7'b1000001};
        logic       vp[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [4:1] vd[5] = '{4'b0001, 4'b1000, 4'b0001, 4'b0001, 4'b1000};
        logic       ve[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:1] vs[5] = '{3'b000, 3'b000, 3'b101, 3'b001, 3'b001};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            code_in = vc[i];
            parity_type = vp[i];
            tick();
            in_valid = 1'b0;
            n_tests++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL vec%0d_latency_early: got %b expected 0", i, out_valid); end
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || data_out !== vd[i] || err_detected !== ve[i] || err_pos !== vs[i]) begin
                n_fail++;
                $display("FAIL vec%0d: got v=%b d=%b e=%b p=%b expected v=1 d=%b e=%b p=%b",
                         i, out_valid, data_out, err_detected, err_pos, vd[i], ve[i], vs[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:1] w[3] = '{7'b0000111, 7'b1000000, 7'b0010000};
        logic       wp[3] = '{1'b0, 1'b1, 1'b0};
        logic [8:0] snap;
        int         base;
        int         cyc;
        base = n_out;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            code_in = w[i];
            parity_type = wp[i];
            #1;
            n_tests++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_accept%0d: in_ready got %b expected 1", i, in_ready); end
            tick();
        end
        code_in = w[2];
        parity_type = wp[2];
        snap = {out_valid, data_out, err_detected, err_pos};
        n_tests++;
        if (snap !== {1'b1, model(w[0], wp[0])}) begin
            n_fail++; $display("FAIL b2b_head: got %h expected %h", snap, {1'b1, model(w[0], wp[0])});
        end
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_in_ready: got %b expected 0", in_ready); end
            tick();
            n_tests++;
            if ({out_valid, data_out, err_detected, err_pos} !== snap) begin
                n_fail++; $display("FAIL b2b_hold: got %h expected %h", {out_valid, data_out, err_detected, err_pos}, snap);
            end
        end
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_release_in_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (n_out < base + 3 && cyc < 10) begin
            tick();
            cyc++;
        end
        tick();
        n_tests++;
        if (n_out != base + 3 || sbq.size() != 0) begin
            n_fail++; $display("FAIL b2b_drain: outputs got %0d expected 3, pending %0d", n_out - base, sbq.size());
        end
    endtask

    task automatic test_counter();
        logic [CNT_W-1:0] e_sat;
        logic [CNT_W-1:0] e_two;
        e_sat = CNT_ON ? 2'd3 : 2'd0;
        e_two = CNT_ON ? 2'd2 : 2'd0;
        out_ready = 1'b1;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        in_valid = 1'b1;
        code_in = 7'b0010111;
        parity_type = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_tests++;
        if (err_count !== e_sat) begin n_fail++; $display("FAIL cnt_saturate: got %0d expected %0d", err_count, e_sat); end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        n_tests++;
        if (err_count !== 2'd0) begin n_fail++; $display("FAIL cnt_clear: got %0d expected 0", err_count); end
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_tests++;
        if (err_count !== e_two) begin n_fail++; $display("FAIL cnt_two: got %0d expected %0d", err_count, e_two); end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        n_tests++;
        if (err_count !== 2'd0) begin n_fail++; $display("FAIL cnt_clr_wins: got %0d expected 0", err_count); end
    endtask

    task automatic test_random_stream();
        int cyc;
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            code_in = 7'($urandom);
            parity_type = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clr = ($urandom_range(0, 31) == 0);
            tick();
        end
        in_valid = 1'b0;
        cnt_clr = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (sbq.size() != 0 && cyc < 10) begin
            tick();
            cyc++;
        end
        n_tests++;
        if (sbq.size() != 0 || n_in != n_out) begin
            n_fail++; $display("FAIL random_drain: delivered %0d accepted %0d pending %0d", n_out, n_in, sbq.size());
        end
    endtask

    task automatic test_reset_flush();
        int base;
        out_ready = 1'b0;
        in_valid = 1'b1;
        parity_type = 1'b0;
        code_in = 7'b0010111;
        tick();
        code_in = 7'b0000110;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready_in_rst: got %b expected 0", in_ready); end
        tick();
        rst = 1'b0;
        base = n_out;
        n_tests++;
        if (out_valid !== 1'b0 || err_count !== '0) begin
            n_fail++; $display("FAIL flush_state: got v=%b cnt=%0d expected v=0 cnt=0", out_valid, err_count);
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        code_in = 7'b1000000;
        parity_type = 1'b1;
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_latency_early: got %b expected 0", out_valid); end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || data_out !== 4'b1000 || err_detected !== 1'b0) begin
            n_fail++; $display("FAIL flush_next_word: got v=%b d=%b e=%b expected v=1 d=1000 e=0", out_valid, data_out, err_detected);
        end
        for (int i = 0; i < 4; i++) tick();
        n_tests++;
        if (n_out != base + 1) begin n_fail++; $display("FAIL flush_no_ghosts: outputs got %0d expected 1", n_out - base); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_counter();
        test_random_stream();
        test_reset_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end
endmodule
